mc_ctrl_hs: RTL and testbench

Multi-cycle RV32I control unit with memory handshake. It replaces the fixed-latency control FSM in the CPU datapath. It sequences fetch, decode, execute, memory and writeback with variable-latency memory (`mem_ready`), an optional memory timeout, illegal-instruction trapping, an ECALL/EBREAK halt, and a retired-instruction counter. It drives the existing datapath muxes and write enables.

---
 rtl/mc_ctrl_pkg.sv | 87 ++++++++
 rtl/mc_ctrl_dec.sv | 56 +++++
 rtl/mc_ctrl_hs.sv | 260 ++++++++++++++++++++++++++
 tb/tb_mc_ctrl_hs.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared types and encodings for the multi-cycle RV32I control unit
//
// Holds the controller state enum, the PC / write-back mux select encodings,
// trap cause codes, RV32I major opcodes, the trap vector address and the
// branch-condition helper used by the top module.
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EX_R,
        S_EX_I,
        S_WB_ALU,
        S_WB_IMM,
        S_WB_AUIPC,
        S_JAL,
        S_ADDR,
        S_JALR,
        S_MEM_RD,
        S_WB_MEM,
        S_MEM_WR,
        S_BR_CMP,
        S_BR_TAKE,
        S_TRAP,
        S_HALT
    } state_e;

    // PC_s mux selects
    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_REL   = 2'd1;
    localparam logic [1:0] PC_ALU   = 2'd2;
    localparam logic [1:0] PC_TRAP  = 2'd3;

    // w_data_s mux selects
    localparam logic [2:0] WD_ALU    = 3'd0;
    localparam logic [2:0] WD_IMM    = 3'd1;
    localparam logic [2:0] WD_MDR    = 3'd2;
    localparam logic [2:0] WD_PC     = 3'd3;
    localparam logic [2:0] WD_PC_REL = 3'd4;

    // trap causes
    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    // RV32I major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // ALU operation codes: {func7[5], func3} for register ops, ADD for address math
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    // Address the datapath loads into PC when PC_s selects the trap vector
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    // Branch condition from the flags of the rs1 - rs2 compare
    function automatic logic branch_cc(
        input logic [2:0] f3,
        input logic       cf,
        input logic       ovf,
        input logic       zf,
        input logic       sf
    );
        logic lt;
        lt = sf ^ ovf;
        case (f3)
            3'b000:  branch_cc = zf;
            3'b001:  branch_cc = ~zf;
            3'b100:  branch_cc = lt;
            3'b101:  branch_cc = ~lt;
            3'b110:  branch_cc = cf;
            3'b111:  branch_cc = ~cf;
            default: branch_cc = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_dec.sv
// rtl/mc_ctrl_dec.sv - combinational instruction class decoder
//
// Inputs : opcode, func3, func7 (fields of the instruction register)
// Outputs: one-hot instruction class flags, illegal, alu_op
module mc_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    output logic       is_r,
    output logic       is_i,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_jalr,
    output logic       is_jal,
    output logic       is_lui,
    output logic       is_auipc,
    output logic       is_halt,
    output logic       illegal,
    output logic [3:0] alu_op
);

    // only func7[5] distinguishes ALU operations (SUB/SRA/SRAI)
    logic unused_func7;
    assign unused_func7 = ^{func7[6], func7[4:0]};

    always_comb begin
        is_r      = (opcode == OP_R);
        is_i      = (opcode == OP_IMM);
        is_load   = (opcode == OP_LOAD);
        is_store  = (opcode == OP_STORE);
        // func3 010/011 has no branch meaning
        is_branch = (opcode == OP_BRANCH) && (func3[2:1] != 2'b01);
        is_jalr   = (opcode == OP_JALR);
        is_jal    = (opcode == OP_JAL);
        is_lui    = (opcode == OP_LUI);
        is_auipc  = (opcode == OP_AUIPC);
        // ECALL/EBREAK share func3 = 0; CSR forms are not supported
        is_halt   = (opcode == OP_SYSTEM) && (func3 == 3'b000);
        illegal   = ~(is_r | is_i | is_load | is_store | is_branch | is_jalr |
                      is_jal | is_lui | is_auipc | is_halt);

        alu_op = ALU_ADD;
        if (is_r) begin
            alu_op = {func7[5], func3};
        end else if (is_i) begin
            // func7[5] is part of the immediate except for the shift-right forms
            alu_op = {(func3 == 3'b101) & func7[5], func3};
        end else if (is_branch) begin
            alu_op = ALU_SUB;
        end
    end

endmodule

// File: rtl/mc_ctrl_hs.sv
// rtl/mc_ctrl_hs.sv - multi-cycle RV32I control FSM with memory handshake
//
// Inputs : clk, rst_ (async active-low), opcode/func3/func7, CF/OF/ZF/SF,
//          mem_ready
// Outputs: ALU_OP, PC_Write, PC0_Write, IR_Write, Reg_Write, Mem_write,
//          mem_req, SE_s, Size_s, PC_s, rs2_imm_s, w_data_s, trap, cause,
//          halted, instret
// Parameters: CNT_W (instret width), WAIT_MAX (memory wait limit, 0 = none)
module mc_ctrl_hs
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 0
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             CF,
    input  logic             OF,
    input  logic             ZF,
    input  logic             SF,
    input  logic             mem_ready,
    output logic [3:0]       ALU_OP,
    output logic             PC_Write,
    output logic             PC0_Write,
    output logic             IR_Write,
    output logic             Reg_Write,
    output logic             Mem_write,
    output logic             mem_req,
    output logic             SE_s,
    output logic [1:0]       Size_s,
    output logic [1:0]       PC_s,
    output logic             rs2_imm_s,
    output logic [2:0]       w_data_s,
    output logic             trap,
    output logic [1:0]       cause,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    // counter only has to reach WAIT_MAX-1: the limit cycle itself decides
    localparam int             WC_W      = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_MAX - 1);

    state_e           state_q, state_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;

    logic dec_r, dec_i, dec_load, dec_store, dec_branch, dec_jalr;
    logic dec_jal, dec_lui, dec_auipc, dec_halt, dec_illegal;
    logic [3:0] dec_alu_op;

    logic in_mem;
    logic timeout_hit;
    logic ls_phase;

    mc_ctrl_dec u_dec (
        .opcode    (opcode),
        .func3     (func3),
        .func7     (func7),
        .is_r      (dec_r),
        .is_i      (dec_i),
        .is_load   (dec_load),
        .is_store  (dec_store),
        .is_branch (dec_branch),
        .is_jalr   (dec_jalr),
        .is_jal    (dec_jal),
        .is_lui    (dec_lui),
        .is_auipc  (dec_auipc),
        .is_halt   (dec_halt),
        .illegal   (dec_illegal),
        .alu_op    (dec_alu_op)
    );

    assign in_mem      = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // mem_ready is tested before timeout_hit everywhere, so a late ready wins
    assign timeout_hit = (WAIT_MAX != 0) && (wait_cnt_q == WAIT_LAST);

    // ---------------- next state, wait counter, instret ----------------
    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        instret_d  = instret_q;
        wait_cnt_d = wait_cnt_q;

        unique case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (dec_r) begin
                    state_d = S_EX_R;
                end else if (dec_i) begin
                    state_d = S_EX_I;
                end else if (dec_load || dec_store || dec_jalr) begin
                    state_d = S_ADDR;
                end else if (dec_branch) begin
                    state_d = S_BR_CMP;
                end else if (dec_lui) begin
                    state_d = S_WB_IMM;
                end else if (dec_auipc) begin
                    state_d = S_WB_AUIPC;
                end else if (dec_jal) begin
                    state_d = S_JAL;
                end else if (dec_halt) begin
                    state_d = S_HALT;
                end
            end
            S_EX_R, S_EX_I: state_d = S_WB_ALU;
            S_ADDR: begin
                if (dec_load) begin
                    state_d = S_MEM_RD;
                end else if (dec_store) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_JALR;
                end
            end
            S_MEM_RD: begin
                if (mem_ready) begin
                    state_d = S_WB_MEM;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_BR_CMP:   state_d = S_BR_TAKE;
            S_WB_ALU, S_WB_IMM, S_WB_AUIPC, S_JAL, S_JALR,
            S_WB_MEM, S_BR_TAKE, S_TRAP:
                        state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_IDLE;
        endcase

        // every entry into a memory state starts a fresh wait window
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (in_mem) begin
            wait_cnt_d = wait_cnt_q + WC_W'(1);
        end

        // an instruction retires when its last state hands back to FETCH;
        // the initial fetch and trap redirects do not count
        if ((state_d == S_FETCH) &&
            !(state_q inside {S_IDLE, S_TRAP, S_FETCH})) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= S_IDLE;
            cause_q    <= CAUSE_NONE;
            instret_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            instret_q  <= instret_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // ---------------- output decode from the registered state ----------------
    always_comb begin
        mem_req   = 1'b0;
        Mem_write = 1'b0;
        IR_Write  = 1'b0;
        PC_Write  = 1'b0;
        PC0_Write = 1'b0;
        Reg_Write = 1'b0;
        rs2_imm_s = 1'b0;
        PC_s      = PC_PLUS4;
        w_data_s  = WD_ALU;
        trap      = 1'b0;
        halted    = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                IR_Write  = mem_ready;
                PC_Write  = mem_ready;
                PC0_Write = mem_ready;
            end
            S_EX_I, S_ADDR: rs2_imm_s = 1'b1;
            S_WB_ALU:       Reg_Write = 1'b1;
            S_WB_IMM: begin
                Reg_Write = 1'b1;
                w_data_s  = WD_IMM;
            end
            S_WB_AUIPC: begin
                Reg_Write = 1'b1;
                w_data_s  = WD_PC_REL;
            end
            S_JAL: begin
                PC_Write  = 1'b1;
                PC_s      = PC_REL;
                Reg_Write = 1'b1;
                w_data_s  = WD_PC;
            end
            S_JALR: begin
                PC_Write  = 1'b1;
                PC_s      = PC_ALU;
                Reg_Write = 1'b1;
                w_data_s  = WD_PC;
            end
            S_MEM_RD:       mem_req = 1'b1;
            S_WB_MEM: begin
                Reg_Write = 1'b1;
                w_data_s  = WD_MDR;
            end
            S_MEM_WR: begin
                mem_req   = 1'b1;
                Mem_write = 1'b1;
            end
            S_BR_TAKE: begin
                PC_Write = branch_cc(func3, CF, OF, ZF, SF);
                PC_s     = PC_REL;
            end
            S_TRAP: begin
                trap     = 1'b1;
                PC_Write = 1'b1;
                PC_s     = PC_TRAP;
            end
            S_HALT:         halted = 1'b1;
            default: ;
        endcase
    end

    // size/sign-extend only while a load or store owns the datapath
    assign ls_phase = (dec_load || dec_store) &&
                      (state_q inside {S_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR});
    assign Size_s   = ls_phase ? func3[1:0] : 2'b00;
    assign SE_s     = ls_phase ? func3[2] : 1'b0;
    assign ALU_OP   = (state_q inside {S_IDLE, S_HALT}) ? 4'd0 : dec_alu_op;

    assign cause    = cause_q;
    assign instret  = instret_q;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// tb/tb_mc_ctrl_hs.sv - self-checking bench for mc_ctrl_hs
module tb_mc_ctrl_hs;

    localparam int CNT_W    = 8;
    localparam int WAIT_MAX = 4;

    // instruction kinds used by the reference model
    localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4, K_JALR = 5;
    localparam int K_JAL = 6, K_LUI = 7, K_AUIPC = 8, K_ILL = 9, K_ILL0 = 10, K_ECALL = 11;

    localparam logic [6:0] RV_OP = 7'h33, RV_IMM = 7'h13, RV_LOAD = 7'h03, RV_STORE = 7'h23;
    localparam logic [6:0] RV_BR = 7'h63, RV_JALR = 7'h67, RV_JAL = 7'h6F, RV_LUI = 7'h37;
    localparam logic [6:0] RV_AUIPC = 7'h17, RV_SYS = 7'h73;

    // observed output vector layout
    localparam logic [16:0] B_MREQ = 17'h10000, B_MW = 17'h08000, B_IRW = 17'h04000;
    localparam logic [16:0] B_PC0W = 17'h02000, B_PCW = 17'h01000, B_RW = 17'h00800;
    localparam logic [16:0] B_TRAP = 17'h00400, B_HALT = 17'h00200, B_RS2 = 17'h00100;

    logic             clk = 1'b0;
    logic             rst_;
    logic [6:0]       opcode, func7;
    logic [2:0]       func3;
    logic             CF, OF, ZF, SF, mem_ready;
    logic [3:0]       ALU_OP;
    logic             PC_Write, PC0_Write, IR_Write, Reg_Write, Mem_write, mem_req;
    logic             SE_s, rs2_imm_s, trap, halted;
    logic [1:0]       Size_s, PC_s, cause;
    logic [2:0]       w_data_s;
    logic [CNT_W-1:0] instret;

    always #5 clk = ~clk;

    mc_ctrl_hs #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst_(rst_), .opcode(opcode), .func3(func3), .func7(func7),
        .CF(CF), .OF(OF), .ZF(ZF), .SF(SF), .mem_ready(mem_ready), .ALU_OP(ALU_OP),
        .PC_Write(PC_Write), .PC0_Write(PC0_Write), .IR_Write(IR_Write),
        .Reg_Write(Reg_Write), .Mem_write(Mem_write), .mem_req(mem_req),
        .SE_s(SE_s), .Size_s(Size_s), .PC_s(PC_s), .rs2_imm_s(rs2_imm_s),
        .w_data_s(w_data_s), .trap(trap), .cause(cause), .halted(halted),
        .instret(instret)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] obs();
        return {mem_req, Mem_write, IR_Write, PC0_Write, PC_Write, Reg_Write, trap,
                halted, rs2_imm_s, SE_s, Size_s, PC_s, w_data_s};
    endfunction

    function automatic logic [16:0] pcs(input int v);
        return 17'(v) << 3;
    endfunction

    function automatic logic [16:0] wd(input int v);
        return 17'(v);
    endfunction

    // reference model state
    int         m_instret = 0;
    logic [1:0] m_cause   = 2'd0;
    logic [16:0] exp_q[$];
    bit          rdy_q[$];
    int          br_f3[6] = '{0, 1, 4, 5, 6, 7};

    task automatic push(input bit rdy, input logic [16:0] v);
        rdy_q.push_back(rdy);
        exp_q.push_back(v);
    endtask

    function automatic bit rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit legal_op(input logic [6:0] op);
        return op inside {RV_OP, RV_IMM, RV_LOAD, RV_STORE, RV_BR, RV_JALR,
                          RV_JAL, RV_LUI, RV_AUIPC, RV_SYS};
    endfunction

    function automatic bit taken(input logic [2:0] f3);
        case (f3)
            3'd0:    return ZF;
            3'd1:    return !ZF;
            3'd4:    return SF != OF;   // signed less-than
            3'd5:    return SF == OF;
            3'd6:    return CF;         // unsigned less-than
            3'd7:    return !CF;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 15);
        if (r < 8)  return 0;
        if (r < 14) return $urandom_range(1, 3);
        return WAIT_MAX + $urandom_range(0, 2);
    endfunction

    // Expected per-cycle outputs of one instruction, from FETCH entry up to
    // (not including) the next FETCH entry.  fw/mw are memory wait cycles.
    task automatic build(input int kind, input int fw, input int mw);
        logic [16:0] ls, base;
        exp_q.delete();
        rdy_q.delete();
        ls = (kind == K_LOAD || kind == K_STORE) ? (17'(func3) << 5) : 17'd0;
        for (int i = 0; i < fw && i < WAIT_MAX; i++) push(1'b0, B_MREQ);
        if (fw >= WAIT_MAX) begin
            push(rnd(), B_TRAP | B_PCW | pcs(3));
            m_cause = 2'd2;
            return;
        end
        push(1'b1, B_MREQ | B_IRW | B_PCW | B_PC0W);
        push(rnd(), 17'd0);
        case (kind)
            K_R:     begin push(rnd(), 17'd0); push(rnd(), B_RW | wd(0)); m_instret++; end
            K_I:     begin push(rnd(), B_RS2); push(rnd(), B_RW | wd(0)); m_instret++; end
            K_LUI:   begin push(rnd(), B_RW | wd(1)); m_instret++; end
            K_AUIPC: begin push(rnd(), B_RW | wd(4)); m_instret++; end
            K_JAL:   begin push(rnd(), B_PCW | pcs(1) | B_RW | wd(3)); m_instret++; end
            K_JALR:  begin
                push(rnd(), B_RS2);
                push(rnd(), B_PCW | pcs(2) | B_RW | wd(3));
                m_instret++;
            end
            K_BR:    begin
                push(rnd(), 17'd0);
                push(rnd(), (taken(func3) ? B_PCW : 17'd0) | pcs(1));
                m_instret++;
            end
            K_LOAD, K_STORE: begin
                push(rnd(), B_RS2 | ls);
                base = B_MREQ | ls | ((kind == K_STORE) ? B_MW : 17'd0);
                for (int i = 0; i < mw && i < WAIT_MAX; i++) push(1'b0, base);
                if (mw >= WAIT_MAX) begin
                    push(rnd(), B_TRAP | B_PCW | pcs(3));
                    m_cause = 2'd2;
                end else begin
                    push(1'b1, base);
                    if (kind == K_LOAD) push(rnd(), B_RW | ls | wd(2));
                    m_instret++;
                end
            end
            K_ECALL: for (int i = 0; i < 20; i++) push(rnd(), B_HALT);
            default: begin
                push(rnd(), B_TRAP | B_PCW | pcs(3));
                m_cause = 2'd1;
            end
        endcase
    endtask

    task automatic run(input string tag, input int ncyc);
        for (int i = 0; i < exp_q.size() && i < ncyc; i++) begin
            mem_ready = rdy_q[i];
            #1;
            check($sformatf("%s cyc%0d", tag, i), 32'(obs()), 32'(exp_q[i]));
            @(negedge clk);
        end
    endtask

    // Called at the negedge that starts a FETCH cycle.
    task automatic do_instr(input int kind, input int fw, input int mw,
                            input int f3, input int zf, input int ncyc);
        logic [2:0] f3v;
        logic [6:0] op;
        check("instret", 32'(instret), 32'(m_instret % (1 << CNT_W)));
        check("cause", 32'(cause), 32'(m_cause));
        f3v   = (f3 >= 0) ? 3'(f3) : 3'($urandom_range(0, 7));
        func7 = rnd() ? 7'h20 : 7'h00;
        {CF, OF, ZF, SF} = 4'($urandom_range(0, 15));
        if (zf >= 0) ZF = zf[0];
        case (kind)
            K_R:     opcode = RV_OP;
            K_I:     opcode = RV_IMM;
            K_LOAD:  opcode = RV_LOAD;
            K_STORE: opcode = RV_STORE;
            K_BR: begin
                opcode = RV_BR;
                if (f3 < 0) f3v = 3'(br_f3[$urandom_range(0, 5)]);
            end
            K_JALR:  opcode = RV_JALR;
            K_JAL:   opcode = RV_JAL;
            K_LUI:   opcode = RV_LUI;
            K_AUIPC: opcode = RV_AUIPC;
            K_ILL0:  opcode = 7'h00;
            K_ECALL: begin opcode = RV_SYS; f3v = 3'd0; end
            default: begin
                case ($urandom_range(0, 3))
                    0: opcode = 7'h00;
                    1: begin
                        do op = 7'($urandom_range(0, 127)); while (legal_op(op));
                        opcode = op;
                    end
                    2: begin opcode = RV_BR; f3v = 3'($urandom_range(2, 3)); end
                    default: begin opcode = RV_SYS; f3v = 3'($urandom_range(1, 7)); end
                endcase
            end
        endcase
        func3 = f3v;
        build(kind, fw, mw);
        run($sformatf("k%0d", kind), ncyc);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " outs"}, 32'(obs()), 32'd0);
        check({tag, " alu_op"}, 32'(ALU_OP), 32'd0);
        check({tag, " instret"}, 32'(instret), 32'd0);
        check({tag, " cause"}, 32'(cause), 32'd0);
    endtask

    // release reset at a negedge, check the single IDLE cycle
    task automatic release_reset();
        @(negedge clk);
        rst_ = 1'b1;
        #1;
        check_all_zero("idle");
        @(negedge clk);
    endtask

    initial begin
        rst_ = 1'b0; mem_ready = 1'b0; opcode = 7'd0; func3 = 3'd0; func7 = 7'd0;
        {CF, OF, ZF, SF} = 4'd0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        release_reset();

        do_instr(K_I, 0, 0, 0, -1, 1000);       // addi, zero-wait
        check("instret after addi", 32'(instret), 32'd1);
        do_instr(K_LOAD, 0, 3, 2, -1, 1000);    // lw with 3 wait cycles
        do_instr(K_BR, 0, 0, 0, 1, 1000);       // beq, ZF=1: taken
        do_instr(K_BR, 0, 0, 1, 1, 1000);       // bne, ZF=1: not taken
        do_instr(K_ILL0, 0, 0, -1, -1, 1000);   // opcode 0000000
        do_instr(K_I, WAIT_MAX, 0, -1, -1, 1000); // fetch timeout
        do_instr(K_I, WAIT_MAX - 1, 0, -1, -1, 1000); // ready on limit cycle
        do_instr(K_STORE, 0, WAIT_MAX - 1, -1, -1, 1000);
        do_instr(K_LOAD, 0, WAIT_MAX, -1, -1, 1000);  // load timeout

        repeat (400) do_instr($urandom_range(0, 9), pick_wait(), pick_wait(), -1, -1, 1000);

        do_instr(K_ECALL, 0, 0, -1, -1, 1000);
        check("instret halted", 32'(instret), 32'(m_instret % (1 << CNT_W)));

        // reset out of HALT
        rst_ = 1'b0;
        #1;
        check_all_zero("reset halt");
        m_instret = 0;
        m_cause   = 2'd0;
        release_reset();

        do_instr(K_I, 0, 0, -1, -1, 1000);
        do_instr(K_ILL0, 0, 0, -1, -1, 1000);
        check("cause before reset", 32'(cause), 32'd1);
        do_instr(K_STORE, 0, 3, -1, -1, 4);     // stop inside MEM_WR
        mem_ready = 1'b0;
        #1;
        check("mid mem_wr", 32'(obs()), 32'(B_MREQ | B_MW | (17'(func3) << 5)));
        #2;
        rst_ = 1'b0;
        #1;
        check_all_zero("reset mem_wr");
        m_instret = 0;
        m_cause   = 2'd0;
        release_reset();
        do_instr(K_LUI, 0, 0, -1, -1, 1000);
        check("instret final", 32'(instret), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
